chacha_xor_stream: RTL
======================

# chacha_xor_stream

Downstream consumer of the ChaCha block datapath. Requests one 512-bit keystream block at a time from the core by presenting a block counter, adds the initial state to the core's working-state output (feed-forward), and XORs the resulting keystream with a 32-bit valid/ready data stream. It advances the block counter every 16 words and re-requests blocks until the message's last word has been transferred.

## Interface
- No parameters. The word width is fixed at 32 bits and the block is fixed at 16 words.
- `clk_i` in 1: the single clock.
- `rst_i` in 1: synchronous, active-high reset.
- `start_i` in 1: begin a message. Sampled only in IDLE. Latches `key_i`, `nonce_i` and `counter_init_i`.
- `key_i` in 256: key. Key word 0 is at [255:224].
- `nonce_i` in 96: nonce. Nonce word 0 is at [95:64].
- `counter_init_i` in 32: first block counter of the message.
- `blk_req_o` out 1: one-cycle pulse asking the core to compute the block for `counter_o`.
- `counter_o` out 32: current block counter. Stable from `blk_req_o` until `blk_done_i`.
- `blk_done_i` in 1: pulse indicating `keystream_i` is valid.
- `keystream_i` in 512: core working state after the rounds. Word k is at [511-32k -: 32].
- `din_valid_i` in 1, `din_ready_o` out 1, `din_data_i` in 32, `din_last_i` in 1: input data stream.
- `dout_valid_o` out 1, `dout_ready_i` in 1, `dout_data_o` out 32, `dout_last_o` out 1: output data stream.
- `busy_o` out 1: high from `start_i` acceptance until the last output word is accepted.
- `ctr_overflow_o` out 1: sticky flag, set when the counter wraps past 0xFFFFFFFF. Cleared by the next accepted `start_i`.

## Operation
- **States:** IDLE, REQ, WAIT, STREAM.
- **IDLE**
  - `start_i` latches the inputs, loads the counter with `counter_init_i`, clears the word index and `ctr_overflow_o`, and moves to REQ.
  - `start_i` is ignored while `busy_o` is high.
- **REQ:** `blk_req_o` = 1 for exactly this cycle, then move to WAIT.
- **WAIT**
  - On `blk_done_i`, capture `ks[k] = keystream_i word k + init word k (mod 2^32)` for k = 0..15, then move to STREAM.
  - Init block = {61707865, 3320646e, 79622d32, 6b206574, key words 0..7, counter_o, nonce words 0..2}, word 0 at the MSB end.
  - `blk_done_i` is ignored in any other state.
- **STREAM**
  - `din_ready_o = (state==STREAM) && (!dout_valid_o || dout_ready_i)`. It is 0 in every other state.
  - On an input handshake:
    - load `dout_data_o = din_data_i ^ ks[idx]` and `dout_last_o = din_last_i`, and set `dout_valid_o`;
    - increment `idx` modulo 16.
  - Last word transferred: go to IDLE. The output register drains independently and `busy_o` drops when it empties.
  - `idx` wraps from 15 to 0 without last: increment `counter_o` and go to REQ.
  - Counter at 0xFFFFFFFF: wraps to 0 and sets `ctr_overflow_o`. Streaming continues.
- **Output register**
  - `dout_valid_o` clears on `dout_ready_i` when no new input word is transferred in the same cycle.
  - Data is held stable while `dout_valid_o && !dout_ready_i`.
- **Reset:** `rst_i` mid-message discards the buffer, pending output and request. Every output returns to its reset value and the FSM goes to IDLE.

## Timing
- **Reset values:** all outputs are 0 and the state is IDLE.
- **Block request:** `start_i` sampled at edge t gives `blk_req_o` high in cycle t+1 and WAIT from t+2.
- **Keystream capture:** `blk_done_i` sampled at edge u gives STREAM and `din_ready_o` (if output is free) in cycle u+1.
- **Throughput:** one word per cycle with `dout_ready_i` held at 1.
- **Output latency:** `dout_valid_o` rises one cycle after the input handshake.
- **Block refill:** the gap between words 15 and 16 of a message is 2 cycles plus the core latency.
- **Simultaneous events:**
  - an output accept and an input accept in the same cycle sustain full rate;
  - `start_i` together with `rst_i` means reset wins.

## Structure
- **Shared package/header `chacha_pkg`:**
  - the four constants `CONST_1..CONST_4`;
  - the word-index macro;
  - the state encoding for IDLE/REQ/WAIT/STREAM.
- **Sub-module `chacha_feedforward`:** combinational 16-way 32-bit adder that builds the init block and adds it to `keystream_i`.
- **Reused:** the codebase `register` and `counter` primitives for the keystream buffer and the word index.

## Test plan
- Stub core returning `keystream_i` = 0 after 3 cycles. Key = 00..1f, nonce = 000000090000004a00000000, `counter_init_i` = 1, `din` word 0 = 0 -> `dout_data_o` = 61707865; word 12 = 00000001; `blk_req_o` exactly one pulse.
- Same setup with a 17-word message -> `blk_req_o` twice, second with `counter_o` = 2; `dout_last_o` only on word 17; `busy_o` falls after its acceptance.
- `dout_ready_i` toggling 1,0,0,1 with input continuously valid -> no word lost or duplicated; `din_ready_o` low while the output register is stalled.
- `counter_init_i` = FFFFFFFF with a 20-word message -> second request with `counter_o` = 0; `ctr_overflow_o` = 1 until the next `start_i`.
- `rst_i` asserted in WAIT and in mid-STREAM -> all outputs 0 next cycle; a late `blk_done_i` is ignored.
- `start_i` pulsed while `busy_o` is high -> ignored; latched key and counter unchanged.

Source files
------------

// File: rtl/chacha_pkg.sv
// Shared ChaCha definitions: sigma constants, block word selection and the
// stream controller state encoding.
package chacha_pkg;

    localparam logic [31:0] CONST_1 = 32'h61707865;
    localparam logic [31:0] CONST_2 = 32'h3320646e;
    localparam logic [31:0] CONST_3 = 32'h79622d32;
    localparam logic [31:0] CONST_4 = 32'h6b206574;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_REQ    = 2'd1,
        ST_WAIT   = 2'd2,
        ST_STREAM = 2'd3
    } state_t;

    // Word 0 of a 512-bit block lives at the MSB end.
    function automatic logic [31:0] word_at(input logic [511:0] blk, input logic [3:0] k);
        return blk[511 - 32*k -: 32];
    endfunction

endpackage

// File: rtl/chacha_feedforward.sv
// Builds the ChaCha initial block from key/counter/nonce and adds it word-wise
// to the core's working state to form the keystream block.
module chacha_feedforward
    import chacha_pkg::*;
(
    input  logic [511:0] keystream_i,
    input  logic [255:0] key_i,
    input  logic [95:0]  nonce_i,
    input  logic [31:0]  counter_i,
    output logic [511:0] sum_o
);

    logic [511:0] init_blk;

    assign init_blk = {CONST_1, CONST_2, CONST_3, CONST_4, key_i, counter_i, nonce_i};

    always_comb begin
        sum_o = '0;
        for (int k = 0; k < 16; k++) begin
            sum_o[511 - 32*k -: 32] = word_at(keystream_i, 4'(k)) + word_at(init_blk, 4'(k));
        end
    end

endmodule

// File: rtl/chacha_xor_stream.sv
// Requests keystream blocks from the ChaCha core and XORs them onto a 32-bit
// data stream, re-requesting with an incremented counter every 16 words.
module chacha_xor_stream
    import chacha_pkg::*;
(
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         start_i,
    input  logic [255:0] key_i,
    input  logic [95:0]  nonce_i,
    input  logic [31:0]  counter_init_i,
    output logic         blk_req_o,
    output logic [31:0]  counter_o,
    input  logic         blk_done_i,
    input  logic [511:0] keystream_i,
    input  logic         din_valid_i,
    output logic         din_ready_o,
    input  logic [31:0]  din_data_i,
    input  logic         din_last_i,
    output logic         dout_valid_o,
    input  logic         dout_ready_i,
    output logic [31:0]  dout_data_o,
    output logic         dout_last_o,
    output logic         busy_o,
    output logic         ctr_overflow_o,
    output logic [1:0]   state_o
);

    // Valid/ready: a word transfers on a rising edge where valid and ready are
    // both high; once valid is raised, data and last hold until that edge.

    state_t        state_q, state_d;
    logic [255:0]  key_q;
    logic [95:0]   nonce_q;
    logic [31:0]   counter_q;
    logic [3:0]    idx_q;
    logic [31:0]   ks_q [16];
    logic [511:0]  ff_sum;
    logic          dout_valid_q;
    logic [31:0]   dout_data_q;
    logic          dout_last_q;
    logic          ovf_q;
    logic          start_ok;
    logic          in_hs;

    chacha_feedforward u_ff (
        .keystream_i (keystream_i),
        .key_i       (key_q),
        .nonce_i     (nonce_q),
        .counter_i   (counter_q),
        .sum_o       (ff_sum)
    );

    assign start_ok = (state_q == ST_IDLE) && start_i && !busy_o;
    assign in_hs    = din_valid_i && din_ready_o;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (start_ok) state_d = ST_REQ;
            ST_REQ:    state_d = ST_WAIT;
            ST_WAIT:   if (blk_done_i) state_d = ST_STREAM;
            ST_STREAM: begin
                if (in_hs) begin
                    if (din_last_i) begin
                        state_d = ST_IDLE;
                    end else if (idx_q == 4'hF) begin
                        state_d = ST_REQ;
                    end
                end
            end
            default:   state_d = ST_IDLE;
        endcase
    end

    // Busy covers the drain of the output register after the FSM returns to IDLE.
    always_comb begin
        blk_req_o   = (state_q == ST_REQ);
        din_ready_o = (state_q == ST_STREAM) && (!dout_valid_q || dout_ready_i);
        busy_o      = (state_q != ST_IDLE) || dout_valid_q;
        state_o     = state_q;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            key_q        <= '0;
            nonce_q      <= '0;
            counter_q    <= '0;
            idx_q        <= '0;
            ovf_q        <= 1'b0;
            dout_valid_q <= 1'b0;
            dout_data_q  <= '0;
            dout_last_q  <= 1'b0;
            for (int k = 0; k < 16; k++) begin
                ks_q[k] <= '0;
            end
        end else begin
            if (start_ok) begin
                key_q     <= key_i;
                nonce_q   <= nonce_i;
                counter_q <= counter_init_i;
                idx_q     <= '0;
                ovf_q     <= 1'b0;
            end
            if ((state_q == ST_WAIT) && blk_done_i) begin
                for (int k = 0; k < 16; k++) begin
                    ks_q[k] <= word_at(ff_sum, 4'(k));
                end
            end
            if (in_hs) begin
                idx_q <= idx_q + 4'd1;
                if (!din_last_i && (idx_q == 4'hF)) begin
                    counter_q <= counter_q + 32'd1;
                    if (counter_q == 32'hFFFF_FFFF) begin
                        ovf_q <= 1'b1;
                    end
                end
            end
            if (in_hs) begin
                dout_valid_q <= 1'b1;
                dout_data_q  <= din_data_i ^ ks_q[idx_q];
                dout_last_q  <= din_last_i;
            end else if (dout_ready_i) begin
                dout_valid_q <= 1'b0;
            end
        end
    end

    assign counter_o      = counter_q;
    assign dout_valid_o   = dout_valid_q;
    assign dout_data_o    = dout_data_q;
    assign dout_last_o    = dout_last_q;
    assign ctr_overflow_o = ovf_q;

endmodule
